mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit producing HI/LO for the single-cycle MIPS core.

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_shift_core.sv | 43 ++++
 rtl/mult_div_unit.sv | 113 +++++++++++
 tb/tb_mult_div_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op and state encodings plus counter sizing for the multiply/divide unit
package mdu_pkg;
  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction
  function automatic logic op_is_div(input logic [1:0] op);
    return op inside {MDU_DIVU, MDU_DIV};
  endfunction
  function automatic logic op_is_signed(input logic [1:0] op);
    return !(op inside {MDU_MULTU, MDU_DIVU});
  endfunction
endpackage

// File: rtl/mdu_shift_core.sv
// mdu_shift_core: shared 2*WIDTH accumulator doing one shift-add multiply or restoring divide step per cycle
module mdu_shift_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_nxt_o
);
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic div_q, div_d;
  logic [WIDTH:0] sum, rem_sh, diff;
  logic ge;
  // multiply: {hi,lo} starts {0,B}, adds A into hi when lo[0] set, shifts right
  // divide: {rem,quo} starts {0,A}, shifts left and subtracts B when it fits
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    ge = rem_sh >= {1'b0, opd_q};
    diff = rem_sh - {1'b0, opd_q};
    acc_nxt_o = div_q ? {ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
                      : {sum, acc_q[WIDTH-1:1]};
    acc_d = load_i ? {{WIDTH{1'b0}}, div_i ? a_i : b_i} : step_i ? acc_nxt_o : acc_q;
    opd_d = load_i ? (div_i ? b_i : a_i) : opd_q;
    div_d = load_i ? div_i : div_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      opd_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opd_q <= opd_d;
      div_q <= div_d;
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit; define MDU_SIGNED_EN to build MULT/DIV sign handling
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MthiEn,
  input  logic             MtloEn,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = cnt_width(WIDTH);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, ma, mb;
  logic [2*WIDTH-1:0] acc_nxt, fix;
  logic start, is_div, last;
  assign start = state_q == IDLE && Start;
  assign is_div = op_is_div(Op);
  assign last = cnt_q == CW'(WIDTH - 1);
`ifdef MDU_SIGNED_EN
  logic sa, sb, neg_q, rneg_q;
  assign sa = op_is_signed(Op) & A[WIDTH-1];
  assign sb = op_is_signed(Op) & B[WIDTH-1];
  assign ma = sa ? -A : A;
  assign mb = sb ? -B : B;
  // quotient/product take the xor of signs, remainder follows the dividend
  assign fix = !div_q ? (neg_q ? -acc_nxt : acc_nxt)
             : {rneg_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH],
                neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (start) begin
      neg_q <= sa ^ sb;
      rneg_q <= sa;
    end
  end
`else
  assign ma = A;
  assign mb = B;
  assign fix = acc_nxt;
`endif
  mdu_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (start),
    .step_i   (state_q == RUN),
    .div_i    (is_div),
    .a_i      (ma),
    .b_i      (mb),
    .acc_nxt_o(acc_nxt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    div_d = div_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (start) begin
      state_d = RUN;
      cnt_d = '0;
      div_d = is_div;
      dz_d = is_div && B == '0;
    end else if (state_q == IDLE) begin
      hi_d = MthiEn ? A : hi_q;
      lo_d = MtloEn ? A : lo_q;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = FINISH;
        hi_d = fix[2*WIDTH-1:WIDTH];
        lo_d = dz_q ? '1 : fix[WIDTH-1:0];
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign Busy = state_q == RUN;
  assign Done = state_q == FINISH;
  assign DivZero = Done & dz_q;
  assign HI = hi_q;
  assign LO = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, Start = 1'b0, MthiEn = 1'b0, MtloEn = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [W-1:0] A = '0, B = '0, HI, LO;
  logic Busy, Done, DivZero;
  logic [64:0] last_e = '0;
  int checks = 0, failures = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .MthiEn(MthiEn), .MtloEn(MtloEn), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // returns {divzero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic sg;
    longint sa, sb, q, r, p;
`ifdef MDU_SIGNED_EN
    sg = op[0];
`else
    sg = 1'b0;
`endif
    sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
    if (!op[1]) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (Done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic mth);
    logic [64:0] e;
    int n;
    e = model(op, a, b);
    Start = 1'b1; Op = op; A = a; B = b; MthiEn = mth;
    tick();
    Start = 1'b0; MthiEn = 1'b0; A = $urandom; B = $urandom;
    chk({tag, ".busy"}, 64'(Busy), 64'd1);
    wait_done(n);
    chk({tag, ".latency"}, 64'(n + 1), 64'(W + 1));
    chk({tag, ".busy_at_done"}, 64'(Busy), 64'd0);
    chk({tag, ".hi"}, 64'(HI), 64'(e[63:32]));
    chk({tag, ".lo"}, 64'(LO), 64'(e[31:0]));
    chk({tag, ".divzero"}, 64'(DivZero), 64'(e[64]));
    tick();
    chk({tag, ".done_pulse"}, 64'(Done), 64'd0);
    last_e = e;
  endtask

  initial begin
    int n;
    logic seen;
    logic [64:0] e1;
    tick(2);
    chk("rst.busy", 64'(Busy), 64'd0);
    chk("rst.done", 64'(Done), 64'd0);
    chk("rst.divzero", 64'(DivZero), 64'd0);
    chk("rst.hi", 64'(HI), 64'd0);
    chk("rst.lo", 64'(LO), 64'd0);
    rst_n = 1'b1;
    tick();

    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max.hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFE);
    chk("multu_max.lo_const", 64'(LO), 64'h0000_0000_0000_0001);

    // abort mid-run: no result and no Done afterwards
    Start = 1'b1; Op = 2'b00; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    tick();
    Start = 1'b0;
    tick(5);
    rst_n = 1'b0;
    tick();
    chk("abort.busy", 64'(Busy), 64'd0);
    chk("abort.hi", 64'(HI), 64'd0);
    chk("abort.lo", 64'(LO), 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (Done) seen = 1'b1;
    end
    chk("abort.no_done", 64'(seen), 64'd0);

    do_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
`ifdef MDU_SIGNED_EN
    chk("mult_m3x7.hi_const", 64'(HI), 64'hFFFF_FFFF);
`else
    chk("mult_m3x7.hi_const", 64'(HI), 64'h0000_0006);
`endif
    chk("mult_m3x7.lo_const", 64'(LO), 64'hFFFF_FFEB);

    do_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef MDU_SIGNED_EN
    chk("div_m7d2.lo_const", 64'(LO), 64'hFFFF_FFFD);
    chk("div_m7d2.hi_const", 64'(HI), 64'hFFFF_FFFF);
`else
    chk("div_m7d2.lo_const", 64'(LO), 64'h7FFF_FFFC);
    chk("div_m7d2.hi_const", 64'(HI), 64'h0000_0001);
`endif

    do_op("divu_100d0", 2'b10, 32'd100, 32'd0, 1'b0);
    chk("divu_100d0.lo_const", 64'(LO), 64'hFFFF_FFFF);
    chk("divu_100d0.hi_const", 64'(HI), 64'd100);
    do_op("div_neg_d0", 2'b11, 32'hFFFF_FF9C, 32'd0, 1'b0);
    do_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("mult_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // Start and MTHI during RUN are ignored; HI/LO show previous result meanwhile
    e1 = model(2'b00, 32'hDEAD_BEEF, 32'h0000_1001);
    Start = 1'b1; Op = 2'b00; A = 32'hDEAD_BEEF; B = 32'h0000_1001;
    tick();
    Start = 1'b0;
    tick(3);
    chk("busy_ign.prev_hi", 64'(HI), 64'(last_e[63:32]));
    chk("busy_ign.prev_lo", 64'(LO), 64'(last_e[31:0]));
    Start = 1'b1; Op = 2'b10; A = 32'd77; B = 32'd5; MthiEn = 1'b1; MtloEn = 1'b1;
    tick();
    Start = 1'b0; MthiEn = 1'b0; MtloEn = 1'b0;
    wait_done(n);
    chk("busy_ign.latency", 64'(n), 64'(W - 4));
    chk("busy_ign.hi", 64'(HI), 64'(e1[63:32]));
    chk("busy_ign.lo", 64'(LO), 64'(e1[31:0]));
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("finish_ign.busy", 64'(Busy), 64'd0);
    tick();
    chk("finish_ign.idle", 64'(Busy), 64'd0);
    chk("finish_ign.hold_hi", 64'(HI), 64'(e1[63:32]));

    MtloEn = 1'b1; A = 32'h0000_1234;
    tick();
    MtloEn = 1'b0;
    chk("mtlo.lo", 64'(LO), 64'h1234);
    chk("mtlo.hi_hold", 64'(HI), 64'(e1[63:32]));
    MthiEn = 1'b1; MtloEn = 1'b1; A = 32'h55AA_33CC;
    tick();
    MthiEn = 1'b0; MtloEn = 1'b0;
    chk("mtboth.hi", 64'(HI), 64'h55AA_33CC);
    chk("mtboth.lo", 64'(LO), 64'h55AA_33CC);

    do_op("start_mthi", 2'b00, 32'h0000_0003, 32'h0000_0005, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? '0 : pick();
      do_op($sformatf("rnd%0d", i), op, a, b, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
